alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered 40-bit ALU between two requesters. It accepts an operation (a, b, 5-bit select) from one requester at a time and drives it onto the ALU. It waits the ALU's pipeline latency, captures the result, and returns it on the winning requester's response channel. It sits between the two datapath clients and the ALU instance; the ALU needs no changes.

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the two-requester ALU arbiter.
// The slave modport is the arbiter's view; master is the clients' and ALU's view.
interface alu_arbiter_if #(
    parameter int W = 40
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [4:0]   req0_s;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [4:0]   req1_s;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [W-1:0] rsp0_out;
    logic         rsp0_err;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp1_out;
    logic         rsp1_err;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [4:0]   alu_s;
    logic [W-1:0] alu_out;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s,
        input  req1_valid, req1_a, req1_b, req1_s,
        input  rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_out, rsp0_err,
        output rsp1_valid, rsp1_out, rsp1_err,
        output alu_a, alu_b, alu_s
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_s,
        output req1_valid, req1_a, req1_b, req1_s,
        output rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_out, rsp0_err,
        input  rsp1_valid, rsp1_out, rsp1_err,
        input  alu_a, alu_b, alu_s
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters:
// accept one op, wait the ALU latency, return the result on the winner's channel.
module alu_arbiter #(
    parameter int          W        = 40,
    parameter int          LAT      = 1,
    parameter logic [15:0] CNT_INIT = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output logic          busy,
    output logic [15:0]   op_count
);
    localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic          last_grant_r;
    logic          gnt_r;
    logic [W-1:0]  rsp_out_r;
    logic          rsp_err_r;
    logic [W-1:0]  alu_a_r;
    logic [W-1:0]  alu_b_r;
    logic [4:0]    alu_s_r;
    logic [15:0]   op_count_r;

    logic          any_req_s;
    logic          sel_s;
    logic [W-1:0]  sel_a_s;
    logic [W-1:0]  sel_b_s;
    logic [4:0]    sel_op_s;
    logic          accept_s;
    logic          hs_s;
    logic          rsp_rdy_s;

    function automatic logic op_supported(input logic [4:0] s);
        logic ok;
        case (s)
            5'b00101, 5'b00111, 5'b00110, 5'b01000,
            5'b01011, 5'b01100, 5'b10100: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Requester selection: a tie goes to whoever was not granted last time
    always_comb begin
        any_req_s = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            sel_s = ~last_grant_r;
        end else if (bus.req1_valid) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        sel_a_s  = sel_s ? bus.req1_a : bus.req0_a;
        sel_b_s  = sel_s ? bus.req1_b : bus.req0_b;
        sel_op_s = sel_s ? bus.req1_s : bus.req0_s;
    end

    // Next-state logic and accept/handshake strobes
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        hs_s      = 1'b0;
        rsp_rdy_s = gnt_r ? bus.rsp1_ready : bus.rsp0_ready;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    accept_s = 1'b1;
                    state_s  = op_supported(sel_op_s) ? EXEC : RESP;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = RESP;
                end else begin
                    state_s = EXEC;
                end
            end
            RESP: begin
                if (rsp_rdy_s) begin
                    hs_s    = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: grant latch, ALU operand issue, latency count, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= {CW{1'b0}};
            last_grant_r <= 1'b1;
            gnt_r        <= 1'b0;
            rsp_out_r    <= {W{1'b0}};
            rsp_err_r    <= 1'b0;
            alu_a_r      <= {W{1'b0}};
            alu_b_r      <= {W{1'b0}};
            alu_s_r      <= 5'b00000;
            op_count_r   <= CNT_INIT;
        end else if (accept_s) begin
            gnt_r        <= sel_s;
            last_grant_r <= sel_s;
            if (op_supported(sel_op_s)) begin
                alu_a_r <= sel_a_s;
                alu_b_r <= sel_b_s;
                alu_s_r <= sel_op_s;
                cnt_r   <= CW'(LAT);
            end else begin
                rsp_out_r <= {W{1'b0}};
                rsp_err_r <= 1'b1;
            end
        end else if (state_r == EXEC) begin
            if (cnt_r == {CW{1'b0}}) begin
                rsp_out_r <= bus.alu_out;
                rsp_err_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CW'(1);
            end
        end else if (hs_s) begin
            op_count_r <= op_count_r + 16'd1;
            alu_s_r    <= 5'b00000;
        end
    end

    assign bus.req0_ready = (state_r == IDLE) & any_req_s & ~sel_s;
    assign bus.req1_ready = (state_r == IDLE) & any_req_s & sel_s;
    assign bus.rsp0_valid = (state_r == RESP) & ~gnt_r;
    assign bus.rsp1_valid = (state_r == RESP) & gnt_r;
    // Response data is forced to zero on a channel that holds no response
    assign bus.rsp0_out   = bus.rsp0_valid ? rsp_out_r : {W{1'b0}};
    assign bus.rsp1_out   = bus.rsp1_valid ? rsp_out_r : {W{1'b0}};
    assign bus.rsp0_err   = bus.rsp0_valid & rsp_err_r;
    assign bus.rsp1_err   = bus.rsp1_valid & rsp_err_r;
    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_s      = alu_s_r;
    assign busy           = (state_r != IDLE);
    assign op_count       = op_count_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed results and a counter-wrap instance.
module tb_alu_arbiter;
    localparam int W   = 40;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.W(W)) bus ();
    logic        busy;
    logic [15:0] op_count;

    alu_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .op_count(op_count)
    );

    // Second instance starts its counter two short of wrapping
    alu_arbiter_if #(.W(W)) wbus ();
    logic        wrst = 1'b1;
    logic        wbusy;
    logic [15:0] wcount;

    alu_arbiter #(.W(W), .LAT(LAT), .CNT_INIT(16'hFFFE)) wdut (
        .clk(clk), .rst(wrst), .bus(wbus), .busy(wbusy), .op_count(wcount)
    );
    assign wbus.alu_out = {W{1'b0}};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [4:0] s);
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        ma = a[W-1] ? (~a + 1'b1) : a;
        mb = b[W-1] ? (~b + 1'b1) : b;
        case (s)
            5'b00101: return a + b;
            5'b00111: return ma + mb;
            5'b00110: return a - b;
            5'b01000: return W'((a != '0) && (b != '0));
            5'b01011: return W'((a != '0) || (b != '0));
            5'b01100: return a << b[5:0];
            5'b10100: return a >> b[5:0];
            default:  return '0;
        endcase
    endfunction

    // Bench-side single-stage ALU
    always @(posedge clk) bus.alu_out <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_s);

    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        else if (v1)  return 1'b1;
        else          return 1'b0;
    endfunction

    // Reference model: one transaction in flight, response visible after a delay
    logic         m_inflight, m_gnt, m_last, m_err;
    int           m_delay;
    logic [W-1:0] m_res, m_alu_a, m_alu_b;
    logic [4:0]   m_alu_s;
    logic [15:0]  m_hs;
    logic [15:0]  cnt_base = 16'h0000;

    logic         w_sel;
    logic [W-1:0] w_a, w_b;
    logic [4:0]   w_s;
    logic         w_ok;
    assign w_sel = pick(bus.req0_valid, bus.req1_valid, m_last);
    assign w_a   = w_sel ? bus.req1_a : bus.req0_a;
    assign w_b   = w_sel ? bus.req1_b : bus.req0_b;
    assign w_s   = w_sel ? bus.req1_s : bus.req0_s;
    assign w_ok  = w_s inside {5'b00101, 5'b00111, 5'b00110, 5'b01000, 5'b01011, 5'b01100, 5'b10100};

    always @(posedge clk) begin
        if (rst) begin
            m_inflight <= 1'b0; m_gnt <= 1'b0; m_last <= 1'b1; m_err <= 1'b0;
            m_delay <= 0; m_res <= '0; m_alu_a <= '0; m_alu_b <= '0;
            m_alu_s <= 5'b00000; m_hs <= 16'h0000;
        end else if (!m_inflight) begin
            if (bus.req0_valid || bus.req1_valid) begin
                m_inflight <= 1'b1;
                m_gnt      <= w_sel;
                m_last     <= w_sel;
                if (w_ok) begin
                    m_delay <= LAT + 1;
                    m_res   <= alu_fn(w_a, w_b, w_s);
                    m_err   <= 1'b0;
                    m_alu_a <= w_a;
                    m_alu_b <= w_b;
                    m_alu_s <= w_s;
                end else begin
                    m_delay <= 0;
                    m_res   <= '0;
                    m_err   <= 1'b1;
                end
            end
        end else if (m_delay > 0) begin
            m_delay <= m_delay - 1;
        end else if (m_gnt ? bus.rsp1_ready : bus.rsp0_ready) begin
            m_inflight <= 1'b0;
            m_hs       <= m_hs + 16'd1;
            m_alu_s    <= 5'b00000;
        end
    end

    logic m_show;
    assign m_show = m_inflight && (m_delay == 0);

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("req0_ready", bus.req0_ready, !m_inflight && (bus.req0_valid || bus.req1_valid) && !w_sel);
            chk("req1_ready", bus.req1_ready, !m_inflight && (bus.req0_valid || bus.req1_valid) && w_sel);
            chk("rsp0_valid", bus.rsp0_valid, m_show && !m_gnt);
            chk("rsp1_valid", bus.rsp1_valid, m_show && m_gnt);
            chk("rsp0_out", bus.rsp0_out, (m_show && !m_gnt) ? m_res : '0);
            chk("rsp1_out", bus.rsp1_out, (m_show && m_gnt) ? m_res : '0);
            chk("rsp0_err", bus.rsp0_err, m_show && !m_gnt && m_err);
            chk("rsp1_err", bus.rsp1_err, m_show && m_gnt && m_err);
            chk("busy", busy, m_inflight);
            chk("op_count", op_count, 16'(cnt_base + m_hs));
            chk("alu_a", bus.alu_a, m_alu_a);
            chk("alu_b", bus.alu_b, m_alu_b);
            chk("alu_s", bus.alu_s, m_alu_s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] s, output int edges, output logic [W-1:0] out,
                         output logic err);
        bit got;
        tick();
        if (n == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_s = s; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_s = s; bus.req1_valid = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((n == 0) ? bus.req0_ready : bus.req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_wait", got, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        edges = 0;
        got   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((n == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
                got = 1'b1;
                break;
            end
            edges++;
        end
        chk("rsp_wait", got, 1'b1);
        out = (n == 0) ? bus.rsp0_out : bus.rsp1_out;
        err = (n == 0) ? bus.rsp0_err : bus.rsp1_err;
    endtask

    int           v_n   [7] = '{0, 1, 1, 0, 1, 0, 1};
    logic [W-1:0] v_a   [7] = '{40'hB, 40'hB, 40'hB, 40'h1, 40'h100, 40'hFFFFFFFFFB, 40'h0};
    logic [W-1:0] v_b   [7] = '{40'h3, 40'h3, 40'h3, 40'h4, 40'h4, 40'h3, 40'h0};
    logic [4:0]   v_s   [7] = '{5'b00101, 5'b00110, 5'b01000, 5'b01100, 5'b10100, 5'b00111, 5'b01011};
    logic [W-1:0] v_exp [7] = '{40'hE, 40'h8, 40'h1, 40'h10, 40'h10, 40'h8, 40'h0};

    initial begin
        int           edges;
        logic [W-1:0] out;
        logic         err;
        int           g [4];
        int           gc;
        bit           got;

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_s = 5'b00000;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_s = 5'b00000;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        wbus.req0_valid = 1'b0; wbus.req0_a = '0; wbus.req0_b = '0; wbus.req0_s = 5'b00000;
        wbus.req1_valid = 1'b1; wbus.req1_a = '0; wbus.req1_b = '0; wbus.req1_s = 5'b11111;
        wbus.rsp0_ready = 1'b1; wbus.rsp1_ready = 1'b1;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_op_count", op_count, 16'h0000);
        chk("reset_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("reset_rsp1_err", bus.rsp1_err, 1'b0);
        chk("reset_alu_s", bus.alu_s, 5'b00000);

        // Single ops on each channel with hand-computed results
        for (int i = 0; i < 7; i++) begin
            issue(v_n[i], v_a[i], v_b[i], v_s[i], edges, out, err);
            chk("vec_out", out, v_exp[i]);
            chk("vec_err", err, 1'b0);
            chk("vec_latency", edges, 2);
            tick();
            @(negedge clk);
            chk("vec_op_count", op_count, 16'(i + 1));
        end

        // Contention: both requesters held valid
        tick();
        bus.req0_a = 40'd5;  bus.req0_b = 40'd6; bus.req0_s = 5'b00101;
        bus.req1_a = 40'd20; bus.req1_b = 40'd7; bus.req1_s = 5'b00110;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        gc = 0;
        for (int k = 0; k < 80 && gc < 4; k++) begin
            @(negedge clk);
            if (bus.req0_ready) begin g[gc] = 0; gc++; end
            else if (bus.req1_ready) begin g[gc] = 1; gc++; end
        end
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("rr_grant_count", gc, 4);
        chk("rr_grant0", g[0], 0);
        chk("rr_grant1", g[1], 1);
        chk("rr_grant2", g[2], 0);
        chk("rr_grant3", g[3], 1);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) begin got = 1'b1; break; end
        end
        chk("rr_drain", got, 1'b1);
        chk("rr_op_count", op_count, 16'd11);

        // Backpressure on channel 0 while req1 waits with an unsupported op
        tick();
        bus.rsp0_ready = 1'b0;
        issue(0, 40'h2, 40'h3, 5'b00101, edges, out, err);
        chk("bp_out", out, 40'h5);
        tick();
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_s = 5'b11111; bus.req1_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.rsp0_valid, 1'b1);
            chk("bp_hold_out", bus.rsp0_out, 40'h5);
            chk("bp_req1_blocked", bus.req1_ready, 1'b0);
        end
        tick();
        bus.rsp0_ready = 1'b1;
        issue(1, '0, '0, 5'b11111, edges, out, err);
        chk("bad_err", err, 1'b1);
        chk("bad_out", out, 40'h0);
        chk("bad_latency", edges, 0);
        chk("bad_alu_s", bus.alu_s, 5'b00000);
        tick();

        // Reset during EXEC discards the operation
        tick();
        bus.req0_a = 40'h1; bus.req0_b = 40'h1; bus.req0_s = 5'b00101; bus.req0_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req0_ready) begin got = 1'b1; break; end
        end
        chk("rst_accept", got, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_count", op_count, 16'h0000);
        chk("rst_alu_a", bus.alu_a, 40'h0);
        chk("rst_alu_s", bus.alu_s, 5'b00000);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_rsp", bus.rsp0_valid, 1'b0);
        end

        // Counter wrap on the preloaded instance
        tick();
        wrst = 1'b0;
        @(negedge clk);
        chk("wrap_start", wcount, 16'hFFFE);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wcount != 16'hFFFE) begin got = 1'b1; break; end
        end
        chk("wrap_step1_seen", got, 1'b1);
        chk("wrap_ffff", wcount, 16'hFFFF);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wcount != 16'hFFFF) begin got = 1'b1; break; end
        end
        chk("wrap_step2_seen", got, 1'b1);
        chk("wrap_zero", wcount, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
